// File: rtl/apb_timer_slave_if.sv
// rtl/apb_timer_slave_if.sv - APB bus bundle between the core's APB master and the timer completer
interface apb_timer_slave_if;
  logic [9:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [1:0]  peripheral_select;
  logic [15:0] prdata;
  logic        pready;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, peripheral_select,
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, peripheral_select,
    output prdata, pready
  );
endinterface

// File: rtl/apb_timer_slave.sv
// rtl/apb_timer_slave.sv - APB completer with wait states and a 4-register down-counting timer
module apb_timer_slave #(
  parameter logic [1:0]  SLAVE_ID    = 2'd1,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] RESET_LOAD  = 16'hFFFF
) (
  input  logic              pclk,
  input  logic              preset,
  apb_timer_slave_if.slave  bus,
  output logic              irq
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] load_q, load_d;
  logic [15:0] count_q, count_d;
  logic        expired_q, expired_d;

  logic        sel;
  logic        pready_w;
  logic        commit;
  logic        wr_commit;
  logic        expire;
  logic [15:0] rdata;

  assign sel       = bus.psel & (bus.peripheral_select == SLAVE_ID);
  assign pready_w  = (state_q == ACCESS) & (wcnt_q == 4'd0);
  assign commit    = pready_w & sel & bus.penable;
  assign wr_commit = commit & bus.pwrite;
  assign expire    = ctrl_q[0] & (count_q == 16'd0);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (sel && !bus.penable) begin
          state_d = ACCESS;
          wcnt_d  = WS;
        end
      end
      ACCESS: begin
        // Losing select mid-transfer aborts without committing anything.
        if (!sel) begin
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else if (commit) begin
          state_d = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;

    if (ctrl_q[0]) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[1]) begin
          count_d = load_q;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
    end

    // Bus writes override the timer update; only an expiry beats a W1C.
    if (wr_commit) begin
      case (bus.paddr[1:0])
        2'd0: ctrl_d = bus.pwdata[2:0];
        2'd1: begin
          load_d  = bus.pwdata;
          count_d = bus.pwdata;
        end
        2'd2: count_d = bus.pwdata;
        2'd3: begin
          if (bus.pwdata[0] && !expire) begin
            expired_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (pready_w && !bus.pwrite) begin
      case (bus.paddr[1:0])
        2'd0:    rdata = {13'd0, ctrl_q};
        2'd1:    rdata = load_q;
        2'd2:    rdata = count_q;
        2'd3:    rdata = {15'd0, expired_q};
        default: rdata = 16'h0000;
      endcase
    end
  end

  assign bus.prdata = rdata;
  assign bus.pready = pready_w;
  assign irq        = expired_q & ctrl_q[2];

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q   <= IDLE;
      wcnt_q    <= 4'd0;
      ctrl_q    <= 3'd0;
      load_q    <= RESET_LOAD;
      count_q   <= RESET_LOAD;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB responder (completer) peripheral for the CID2 SoC APB bus; it sits at the far end of the core's APB master, on one `peripheral_select` slot.
- Decodes SETUP/ACCESS phases and inserts a configurable number of wait states via `pready`.
- Exposes a 4-register down-counting timer (CTRL, LOAD, COUNT, STATUS) with an interrupt output.
- Responds only when `psel` is high and `peripheral_select` equals `SLAVE_ID`.

Parameters:
- SLAVE_ID, 2'd1, value of `peripheral_select` that addresses this block.
- WAIT_STATES, 0, cycles `pready` is held low in the ACCESS phase (0..15).
- RESET_LOAD, 16'hFFFF, reset value of LOAD and COUNT.

Ports:
- pclk  in  1  clock; all state changes on rising edge.
- preset  in  1  reset, asynchronous, active-low.
- paddr  in  10  byte address; `paddr[1:0]` selects the register, `paddr[9:2]` is ignored (aliased).
- psel  in  1  APB select.
- penable  in  1  APB enable (high in ACCESS phase).
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  16  write data.
- peripheral_select  in  2  slot decode from the master.
- prdata  out  16  read data.
- pready  out  1  transfer complete.
- irq  out  1  timer interrupt, level.

Behaviour:
- sel = `psel` & (`peripheral_select` == SLAVE_ID).
- Reset (`preset` low, asynchronous, any state):
  - state = IDLE, wcnt = 0.
  - CTRL = 0, LOAD = COUNT = RESET_LOAD, STATUS = 0.
  - Outputs `prdata` = 0, `pready` = 0, `irq` = 0.
  - A transfer in flight is dropped with no register side effects.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when sel & ~`penable` is sampled; wcnt <= WAIT_STATES.
  - In ACCESS: wcnt decrements by 1 per cycle while > 0.
  - ACCESS -> IDLE at the edge where sel & `penable` & `pready` (transfer commit).
  - ACCESS -> IDLE if sel is sampled low (abort): no commit, no side effects.
- `pready` = (state == ACCESS) & (wcnt == 0), combinational from registered state; 0 in IDLE.
- With WAIT_STATES = 0 a transfer takes 2 cycles (setup + access).
- Back-to-back: the master's next SETUP arrives in the cycle after commit while the FSM is in IDLE. It is accepted normally; no dead cycle is added.
- `prdata` = selected register while `pready` & ~`pwrite` in ACCESS, else 16'h0000.
- Register map (`paddr[1:0]`):
  - 0 CTRL (RW): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits 15:3 read 0, writes ignored.
  - 1 LOAD (RW): a write also copies `pwdata` into COUNT.
  - 2 COUNT (RW): current counter value.
  - 3 STATUS: bit0 EXPIRED, write-1-to-clear; other bits read 0.
- Writes commit only on the commit edge. Reads have no side effects.
- Counter, each cycle with EN = 1:
  - COUNT != 0: COUNT <= COUNT - 1.
  - COUNT == 0: EXPIRED <= 1; if AUTO_RELOAD, COUNT <= LOAD, else EN <= 0 and COUNT stays 0.
- `irq` = EXPIRED & IRQ_EN, registered from the state bits (no added latency beyond the STATUS/CTRL flops).
- Simultaneous events, same edge:
  - Bus write to COUNT or LOAD vs. decrement/reload: the bus write wins.
  - STATUS W1C vs. expiry: the set wins, EXPIRED stays 1.
  - Bus write to CTRL clearing EN vs. expiry: EXPIRED is still set, EN = 0.
- Unselected slot (`peripheral_select` != SLAVE_ID): block stays IDLE, `pready` = 0, `prdata` = 0.

Test Plan:
- Reset: drive `preset` low mid-ACCESS -> `pready` = 0 and `prdata` = 0 immediately. After release, reading LOAD returns 16'hFFFF and STATUS returns 16'h0000.
- WAIT_STATES = 0: write LOAD = 16'h0005 at `paddr` 1 -> `pready` high in the 2nd cycle; a following read of COUNT (`paddr` 2) returns 16'h0005 in its access cycle.
- WAIT_STATES = 3: read CTRL -> `pready` low for 3 access cycles, high on the 4th with `prdata` = 16'h0000. No write side effects occur before the commit edge.
- One-shot: LOAD = 3, CTRL = 16'h0005 -> EXPIRED = 1 and `irq` = 1 after 4 enabled cycles; EN reads back 0 and COUNT = 0.
  - Then write STATUS = 16'h0001 -> `irq` drops the next cycle.
- Auto-reload plus collision: LOAD = 2, CTRL = 16'h0007 -> COUNT sequence 2,1,0,2,1,0.
  - A STATUS W1C committed on the expiry edge leaves EXPIRED = 1.
- Decode and abort: `peripheral_select` = 2 with `psel` = 1 -> `pready` stays 0 and registers are unchanged.
  - `psel` dropped mid-wait -> FSM returns to IDLE and the pending write is discarded.
